// File: rtl/water_arbiter.sv
// rtl/water_arbiter.sv - round-robin time-sliced arbiter sharing one pump between two stations
module water_arbiter #(
  parameter int SLICE  = 16,
  parameter int SETTLE = 2,
  parameter int CW     = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] G1,
  input  logic [1:0] G2,
  input  logic [1:0] fault,
  output logic [1:0] R1,
  output logic [1:0] R2,
  output logic       pump,
  output logic [1:0] gnt,
  output logic [1:0] E
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_GRANT1 = 3'd2,
    ST_GRANT2 = 3'd3,
    ST_LOCK   = 3'd4
  } state_t;

  localparam logic [CW-1:0] SLICE_LAST  = CW'(SLICE - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  state_t        state, state_n;
  logic          last, last_n;  // last-served station: 0 = station 1, 1 = station 2
  logic          tgt, tgt_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    mode, mode_n;
  logic [1:0]    tgt_mode, own_mode, other_mode;
  logic          other_idx;

  assign tgt_mode   = tgt ? G2 : G1;
  assign own_mode   = (state == ST_GRANT2) ? G2 : G1;
  assign other_mode = (state == ST_GRANT2) ? G1 : G2;
  assign other_idx  = (state == ST_GRANT1);

  always_comb begin
    state_n = state;
    last_n  = last;
    tgt_n   = tgt;
    cnt_n   = cnt;
    mode_n  = mode;
    if (fault != 2'b00) begin
      state_n = ST_LOCK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (G1 != 2'b00 || G2 != 2'b00) begin
            state_n = ST_SETTLE;
            cnt_n   = '0;
            tgt_n   = (G1 != 2'b00 && G2 != 2'b00) ? ~last : (G2 != 2'b00);
          end
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            if (tgt_mode == 2'b00) begin
              state_n = ST_IDLE;
            end else begin
              state_n = tgt ? ST_GRANT2 : ST_GRANT1;
              mode_n  = tgt_mode;
              cnt_n   = '0;
              last_n  = tgt;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_GRANT1, ST_GRANT2: begin
          // release wins over slice expiry; both hand over to the waiting station
          if (own_mode == 2'b00) begin
            if (other_mode != 2'b00) begin
              state_n = ST_SETTLE;
              tgt_n   = other_idx;
              cnt_n   = '0;
            end else begin
              state_n = ST_IDLE;
            end
          end else if (cnt == SLICE_LAST) begin
            if (other_mode != 2'b00) begin
              state_n = ST_SETTLE;
              tgt_n   = other_idx;
              cnt_n   = '0;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_LOCK: begin
          if (G1 == 2'b00 && G2 == 2'b00) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // outputs are decoded from the next state so they register alongside it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      last  <= 1'b1;
      tgt   <= 1'b0;
      cnt   <= '0;
      mode  <= 2'b00;
      R1    <= 2'b00;
      R2    <= 2'b00;
      pump  <= 1'b0;
      gnt   <= 2'b00;
      E     <= 2'b00;
    end else begin
      state <= state_n;
      last  <= last_n;
      tgt   <= tgt_n;
      cnt   <= cnt_n;
      mode  <= mode_n;
      R1    <= (state_n == ST_GRANT1) ? mode_n : 2'b00;
      R2    <= (state_n == ST_GRANT2) ? mode_n : 2'b00;
      pump  <= (state_n == ST_GRANT1) || (state_n == ST_GRANT2);
      gnt   <= {state_n == ST_GRANT2, state_n == ST_GRANT1};
      E     <= (state_n == ST_LOCK) ? 2'b11 : 2'b00;
    end
  end

endmodule

// File: tb/tb_water_arbiter.sv
// tb/tb_water_arbiter.sv - scoreboard bench for water_arbiter against a behavioural model
module tb_water_arbiter;

  localparam int SLICE_P  = 4;
  localparam int SETTLE_P = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] G1 = 2'b00, G2 = 2'b00, fault = 2'b00;
  logic [1:0] R1, R2, gnt, E;
  logic       pump;

  water_arbiter #(.SLICE(SLICE_P), .SETTLE(SETTLE_P), .CW(5)) dut (
    .clk(clk), .reset_n(reset_n), .G1(G1), .G2(G2), .fault(fault),
    .R1(R1), .R2(R2), .pump(pump), .gnt(gnt), .E(E)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];

  // model: phase 0 idle, 1 closed/settling, 2 serving, 3 locked out
  int m_phase, m_holder, m_tgt, m_last, m_left, m_age;
  logic [1:0] m_mode;

  task automatic model_reset();
    m_phase = 0; m_holder = 0; m_tgt = 0; m_last = 2; m_left = 0; m_age = 0; m_mode = 2'b00;
  endtask

  task automatic model_step(input logic [1:0] a, input logic [1:0] b, input logic [1:0] f);
    logic [1:0] mine, other, m;
    if (f != 2'b00) begin
      m_phase = 3;
    end else if (m_phase == 0) begin
      if (a != 0 || b != 0) begin
        if (a != 0 && b != 0) m_tgt = (m_last == 1) ? 2 : 1;
        else m_tgt = (a != 0) ? 1 : 2;
        m_phase = 1; m_left = SETTLE_P;
      end
    end else if (m_phase == 1) begin
      m_left--;
      if (m_left == 0) begin
        m = (m_tgt == 1) ? a : b;
        if (m == 0) m_phase = 0;
        else begin
          m_phase = 2; m_holder = m_tgt; m_mode = m; m_age = 1; m_last = m_tgt;
        end
      end
    end else if (m_phase == 2) begin
      mine  = (m_holder == 1) ? a : b;
      other = (m_holder == 1) ? b : a;
      if (mine == 0 || (m_age >= SLICE_P && other != 0)) begin
        if (other != 0) begin
          m_phase = 1; m_left = SETTLE_P; m_tgt = 3 - m_holder;
        end else m_phase = 0;
      end else if (m_age < SLICE_P) m_age++;
    end else begin
      if (a == 0 && b == 0) m_phase = 0;
    end
  endtask

  function automatic logic [8:0] model_out();
    logic [1:0] r1, r2, g, e;
    logic p;
    r1 = (m_phase == 2 && m_holder == 1) ? m_mode : 2'b00;
    r2 = (m_phase == 2 && m_holder == 2) ? m_mode : 2'b00;
    p  = (m_phase == 2);
    g  = (m_phase == 2) ? ((m_holder == 1) ? 2'b01 : 2'b10) : 2'b00;
    e  = (m_phase == 3) ? 2'b11 : 2'b00;
    return {r1, r2, p, g, e};
  endfunction

  task automatic check(input logic [8:0] exp, input string tag);
    logic [8:0] act;
    act = {R1, R2, pump, gnt, E};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got {R1,R2,pump,gnt,E}=%b expected %b", tag, $time, act, exp);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) check(exp_q.pop_front(), "edge_outputs");
  end

  always begin
    @(negedge reset_n);
    #1;
    if (exp_q.size() > 0) check(exp_q.pop_front(), "async_reset");
  end

  task automatic step(input logic [1:0] a, input logic [1:0] b, input logic [1:0] f);
    G1 = a; G2 = b; fault = f;
    model_step(a, b, f);
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic hold(input logic [1:0] a, input logic [1:0] b, input logic [1:0] f, input int n);
    for (int i = 0; i < n; i++) step(a, b, f);
  endtask

  // called at a negedge; reset asserts between edges so the immediate clear is observable
  task automatic do_reset(input int n);
    exp_q.push_back(9'b0);
    #2 reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(9'b0);
      @(negedge clk);
    end
    reset_n = 1'b1;
  endtask

  initial begin
    logic [1:0] a, b, f;
    @(negedge clk);
    do_reset(2);
    hold(2'b01, 2'b00, 2'b00, 12);

    do_reset(1);
    hold(2'b10, 2'b11, 2'b00, 30);

    do_reset(1);
    hold(2'b01, 2'b00, 2'b00, 6);
    hold(2'b00, 2'b00, 2'b00, 3);

    hold(2'b01, 2'b00, 2'b00, 5);
    hold(2'b10, 2'b00, 2'b00, 5);
    hold(2'b00, 2'b00, 2'b00, 2);
    hold(2'b10, 2'b00, 2'b00, 5);

    do_reset(1);
    hold(2'b00, 2'b10, 2'b00, 5);
    hold(2'b00, 2'b10, 2'b01, 1);
    hold(2'b00, 2'b10, 2'b00, 3);
    hold(2'b00, 2'b00, 2'b00, 2);
    hold(2'b01, 2'b01, 2'b00, 8);

    hold(2'b01, 2'b00, 2'b00, 5);
    do_reset(2);
    hold(2'b11, 2'b01, 2'b00, 12);

    a = 2'b00; b = 2'b00; f = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) b = 2'($urandom_range(0, 3));
      if (f != 2'b00) begin
        if ($urandom_range(0, 1) == 0) f = 2'b00;
      end else if ($urandom_range(0, 49) == 0) f = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 2));
      else step(a, b, f);
    end

    hold(2'b00, 2'b00, 2'b00, 2);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
